// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: forwards operands at capture, selects immediate for B and
// holds issued work in a 2-entry skid buffer that snoops the WB bus while held.

module alu_issue_fwd #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  logic              ex_valid_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [XLEN-1:0]   ex_data_i,
  input  logic              wb_valid_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic [XLEN-1:0]   data_o
);
  // x0 reads as zero even if a producer claims rd=0; EX beats WB.
  assign data_o = (addr_i == '0)                       ? '0        :
                  (ex_valid_i && (ex_rd_i == addr_i))  ? ex_data_i :
                  (wb_valid_i && (wb_rd_i == addr_i))  ? wb_data_i :
                                                         rf_data_i;
endmodule

module alu_issue_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic              use_imm_i,
  input  logic [4:0]        alu_op_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              fwd_ex_valid_i,
  input  logic [REG_AW-1:0] fwd_ex_rd_i,
  input  logic [XLEN-1:0]   fwd_ex_data_i,
  input  logic              fwd_wb_valid_i,
  input  logic [REG_AW-1:0] fwd_wb_rd_i,
  input  logic [XLEN-1:0]   fwd_wb_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   a_o,
  output logic [XLEN-1:0]   b_o,
  output logic [4:0]        alu_op_o,
  output logic [REG_AW-1:0] rd_addr_o
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [4:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_imm;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d, new_e;

  logic [1:0][REG_AW-1:0] src_addr;
  logic [1:0][XLEN-1:0]   src_rf, src_fwd;
  logic                   accept, issue;

  assign src_addr = {rs2_addr_i, rs1_addr_i};
  assign src_rf   = {rs2_data_i, rs1_data_i};

  for (genvar s = 0; s < 2; s++) begin : g_src
    alu_issue_fwd #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd (
      .addr_i    (src_addr[s]),
      .rf_data_i (src_rf[s]),
      .ex_valid_i(fwd_ex_valid_i),
      .ex_rd_i   (fwd_ex_rd_i),
      .ex_data_i (fwd_ex_data_i),
      .wb_valid_i(fwd_wb_valid_i),
      .wb_rd_i   (fwd_wb_rd_i),
      .wb_data_i (fwd_wb_data_i),
      .data_o    (src_fwd[s])
    );
  end

  // Held entries only see WB; an EX producer of a held source retires via WB later.
  function automatic entry_t snoop(entry_t e, logic v, logic [REG_AW-1:0] rd,
                                   logic [XLEN-1:0] d);
    entry_t r;
    r = e;
    if (v && (e.rs1 != '0) && (e.rs1 == rd)) r.a = d;
    if (v && !e.use_imm && (e.rs2 != '0) && (e.rs2 == rd)) r.b = d;
    return r;
  endfunction

  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign accept      = in_valid_i & in_ready_o;
  assign issue       = out_valid_o & out_ready_i;

  always_comb begin
    new_e.a       = src_fwd[0];
    new_e.b       = use_imm_i ? imm_i : src_fwd[1];
    new_e.op      = alu_op_i;
    new_e.rd      = rd_addr_i;
    new_e.rs1     = rs1_addr_i;
    new_e.rs2     = rs2_addr_i;
    new_e.use_imm = use_imm_i;
  end

  always_comb begin
    state_d = state_q;
    main_d  = snoop(main_q, fwd_wb_valid_i, fwd_wb_rd_i, fwd_wb_data_i);
    skid_d  = snoop(skid_q, fwd_wb_valid_i, fwd_wb_rd_i, fwd_wb_data_i);
    case (state_q)
      EMPTY: if (accept) begin
        main_d  = new_e;
        state_d = ONE;
      end
      ONE: begin
        if (accept && issue) main_d = new_e;
        else if (accept) begin
          skid_d  = new_e;
          state_d = FULL;
        end else if (issue) state_d = EMPTY;
      end
      FULL: if (issue) begin
        main_d  = skid_d;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) state_d = EMPTY;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign a_o       = main_q.a;
  assign b_o       = main_q.b;
  assign alu_op_o  = main_q.op;
  assign rd_addr_o = main_q.rd;
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue stage directly upstream of the RV32 ALU.
- Takes decoded instructions from the decoder and resolves operand hazards via EX and WB forwarding.
- Selects register or immediate for operand B.
- Holds issued operands in a 2-entry skid buffer with valid/ready handshakes on both sides. a_o/b_o/alu_op_o drive the ALU's a_i/b_i/alu_op_i.

Parameters:
- XLEN, 32, operand/result width
- REG_AW, 5, register address width

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  synchronous reset, active-low
- flush_i  in  1  discard all held entries (branch mispredict/trap)
- in_valid_i  in  1  decoder presents an instruction
- in_ready_o  out  1  stage accepts this cycle
- rs1_addr_i  in  REG_AW  source 1 index
- rs2_addr_i  in  REG_AW  source 2 index
- rs1_data_i  in  XLEN  register file read data 1
- rs2_data_i  in  XLEN  register file read data 2
- imm_i  in  XLEN  sign-extended immediate
- use_imm_i  in  1  1: B = imm_i; 0: B = rs2 operand
- alu_op_i  in  5  ALU opcode, passed through unchanged
- rd_addr_i  in  REG_AW  destination index
- fwd_ex_valid_i  in  1  EX result forwarding valid
- fwd_ex_rd_i  in  REG_AW  EX destination
- fwd_ex_data_i  in  XLEN  EX result (registered ALU result_o)
- fwd_wb_valid_i  in  1  WB forwarding valid
- fwd_wb_rd_i  in  REG_AW  WB destination
- fwd_wb_data_i  in  XLEN  WB data
- out_valid_o  out  1  a_o/b_o/alu_op_o/rd_addr_o valid
- out_ready_i  in  1  ALU/EX stage consumes this cycle
- a_o  out  XLEN  operand A to ALU
- b_o  out  XLEN  operand B to ALU
- alu_op_o  out  5  opcode to ALU
- rd_addr_o  out  REG_AW  destination passed downstream

Behaviour:
- Handshakes:
  - Accept = in_valid_i & in_ready_o.
  - Issue = out_valid_o & out_ready_i.
  - out_valid_o deasserts only after issue or flush.
  - Outputs are held stable while out_valid_o & !out_ready_i.
- Forwarding at capture, per source:
  - If the address is 0, operand = 0.
  - Else if fwd_ex_valid_i & rd match, use fwd_ex_data_i.
  - Else if fwd_wb_valid_i & rd match, use fwd_wb_data_i.
  - Else use register file data.
  - EX has priority over WB.
- B select: use_imm_i ? imm_i : forwarded rs2. Entries with use_imm=1 ignore rs2 in all snooping.
- Snoop while held:
  - Each held entry stores rs1/rs2 addresses and use_imm.
  - Every cycle, if fwd_wb_valid_i matches a nonzero stored rs (and not immediate for B), the stored operand updates to fwd_wb_data_i.
  - The EX bus is not snooped after capture.
- Buffer FSM, registered state {EMPTY, ONE, FULL}; in_ready_o = (state != FULL), registered (no combinational path from out_ready_i):
  - EMPTY: accept → ONE.
  - ONE: accept & !issue → FULL (new entry to skid); issue & !accept → EMPTY; accept & issue → ONE (new entry to main).
  - FULL: issue → ONE (skid moves to main, same cycle); no accept possible.
- Ordering: strictly in order; the skid entry never issues before main.
- flush_i:
  - Next state EMPTY, out_valid_o=0 the next cycle.
  - An accept in the same cycle is discarded.
  - An issue in the same cycle still counts for downstream.
  - in_ready_o=1 the next cycle.
- Reset (rst_ni=0 at a clock edge):
  - State EMPTY; out_valid_o=0; a_o=b_o=0; alu_op_o=0; rd_addr_o=0; in_ready_o=1.
  - Reset mid-FULL discards both entries.
  - rst_ni has priority over flush_i.
- Latency: 1 cycle from accept to out_valid_o when EMPTY; throughput 1 instruction/cycle with out_ready_i=1.
- Width: no arithmetic; all operand paths XLEN bits, no extension.

Test Plan:
- Reset → out_valid_o=0, in_ready_o=1, a_o=b_o=0; then accept rs1=3 (data 0x10), imm 0x5, use_imm=1, op=ADD, out_ready_i=1 → next cycle a_o=0x10, b_o=0x5, out_valid_o=1 for exactly 1 cycle.
- Forwarding priority: rs1=rs2=7, EX rd=7 data 0xAA, WB rd=7 data 0xBB, regfile 0x11 → a_o=b_o=0xAA; rs1=0 with EX rd=0 valid → a_o=0.
- Backpressure: out_ready_i=0, 3 back-to-back valid inputs (A,B,C) → A,B accepted, in_ready_o=0 in the third cycle, C stalled; release out_ready_i → A, B, C issued in order with no loss or duplication.
- Snoop: entry with rs2=9 held in skid; WB writes rd=9 data 0x1234 → when issued, b_o=0x1234; same with use_imm=1 → b_o=imm unchanged.
- Flush in FULL with simultaneous in_valid_i → next cycle out_valid_o=0, in_ready_o=1, the flushed-cycle instruction is never issued.
- Reset asserted in FULL with flush_i=1 → next cycle all outputs at reset values; the first post-reset accept issues normally.
